data_cache: RTL and testbench

//  Direct-mapped, write-back, write-allocate data cache between the pipeline's MEM-stage port (read_m2/write_m2/address2/data2 side) and main memory.

---
 rtl/data_cache.sv | 166 ++++++++++++++++
 tb/tb_data_cache.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache: 8 lines x 4 words, 0-wait hits.
// Optional hit/miss counters (num_hit, num_miss) are built when CACHE_STATS_EN is defined.
module data_cache (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [15:0] cpu_address,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        cpu_ready,
    output logic        mem_read,
    output logic        mem_write,
    output logic [15:0] mem_address,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata,
    input  logic        mem_ready
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0] num_hit,
    output logic [15:0] num_miss
`endif
);

    localparam int unsigned WORD_SIZE = 16;
    localparam int unsigned LINE_W    = 64;
    localparam int unsigned NUM_LINES = 8;
    localparam int unsigned INDEX_W   = 3;
    localparam int unsigned TAG_W     = 11;

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

    state_t state, state_next;

    logic [NUM_LINES-1:0] valid, dirty;
    logic [TAG_W-1:0]     tags  [NUM_LINES];
    logic [LINE_W-1:0]    lines [NUM_LINES];

    logic [TAG_W-1:0]   tag;
    logic [INDEX_W-1:0] index;
    logic [1:0]         offset;
    logic               request, hit;
    logic               hit_write, start_wb, start_alloc, wb_done, fill;

    assign tag     = cpu_address[15:5];
    assign index   = cpu_address[4:2];
    assign offset  = cpu_address[1:0];
    assign request = cpu_read || cpu_write;
    assign hit     = valid[index] && (tags[index] == tag);

    // Next state and the combinational hit response; everything is quiet while in reset
    always_comb begin
        state_next  = state;
        cpu_ready   = 1'b0;
        cpu_rdata   = '0;
        hit_write   = 1'b0;
        start_wb    = 1'b0;
        start_alloc = 1'b0;
        wb_done     = 1'b0;
        fill        = 1'b0;
        if (reset_n) begin
            unique case (state)
                IDLE: begin
                    if (request) begin
                        if (hit) begin
                            cpu_ready = 1'b1;
                            cpu_rdata = lines[index][{offset, 4'b0000} +: WORD_SIZE];
                            hit_write = cpu_write;
                        end else if (valid[index] && dirty[index]) begin
                            state_next = WRITEBACK;
                            start_wb   = 1'b1;
                        end else begin
                            state_next  = ALLOCATE;
                            start_alloc = 1'b1;
                        end
                    end
                end
                WRITEBACK: begin
                    if (mem_ready) begin
                        state_next = ALLOCATE;
                        wb_done    = 1'b1;
                    end
                end
                ALLOCATE: begin
                    if (mem_ready) begin
                        state_next = IDLE;
                        fill       = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // State register, line status bits and the registered memory request
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            valid       <= '0;
            dirty       <= '0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
        end else begin
            state <= state_next;
            if (start_wb) begin
                mem_write   <= 1'b1;
                mem_address <= {tags[index], index, 2'b00};
                mem_wdata   <= lines[index];
            end
            if (start_alloc || wb_done) begin
                mem_read    <= 1'b1;
                mem_address <= {cpu_address[15:2], 2'b00};
            end
            if (wb_done) begin
                mem_write    <= 1'b0;
                dirty[index] <= 1'b0;
            end
            if (fill) begin
                mem_read     <= 1'b0;
                valid[index] <= 1'b1;
                dirty[index] <= 1'b0;
            end
            if (hit_write) begin
                dirty[index] <= 1'b1;
            end
        end
    end

    // Tag and data arrays carry no reset; their contents only matter once valid is set
    always_ff @(posedge clk) begin
        if (fill) begin
            lines[index] <= mem_rdata;
            tags[index]  <= tag;
        end else if (hit_write) begin
            lines[index][{offset, 4'b0000} +: WORD_SIZE] <= cpu_wdata;
        end
    end

`ifdef CACHE_STATS_EN
    // The first IDLE cycle after a fill is the held request re-hitting; it is not a fresh hit
    logic after_fill;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            num_hit    <= '0;
            num_miss   <= '0;
            after_fill <= 1'b0;
        end else begin
            if (fill) begin
                after_fill <= 1'b1;
            end else if (state == IDLE) begin
                after_fill <= 1'b0;
            end
            if (cpu_ready && !after_fill) begin
                num_hit <= num_hit + 16'd1;
            end
            if (start_wb || start_alloc) begin
                num_miss <= num_miss + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: a word-addressed memory view plus a tag/dirty model
// predicts read data, stall length and write-back traffic for directed and random accesses.
`timescale 1ns/1ps
module tb_data_cache;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cpu_read = 1'b0, cpu_write = 1'b0;
    logic [15:0] cpu_address = '0, cpu_wdata = '0;
    logic [15:0] cpu_rdata;
    logic        cpu_ready;
    logic        mem_read, mem_write;
    logic [15:0] mem_address;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_ready;
`ifdef CACHE_STATS_EN
    logic [15:0] num_hit, num_miss;
`endif

    data_cache dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_read(cpu_read), .cpu_write(cpu_write),
        .cpu_address(cpu_address), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
`ifdef CACHE_STATS_EN
        ,
        .num_hit(num_hit), .num_miss(num_miss)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int lat = 3;

    // Backing memory (line granular) and the coherent word view the CPU should observe
    logic [63:0] mem_line [16384];
    logic [15:0] ref_word [65536];

    // Abstract cache directory: which line sits in each slot and whether it was modified
    bit          m_valid [8];
    bit          m_dirty [8];
    logic [10:0] m_tag   [8];
    int          m_hits = 0;
    int          m_misses = 0;

    int          wb_count = 0;
    logic [15:0] wb_addr = '0;
    logic [63:0] wb_data = '0;

    // Memory responder: mem_ready pulses once the request has been seen for lat cycles
    initial begin
        int cnt;
        cnt = 0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_ready) begin
                mem_ready = 1'b0;
                cnt = 0;
            end else if (mem_read || mem_write) begin
                cnt++;
                if (cnt >= lat) begin
                    if (mem_write) begin
                        mem_line[mem_address[15:2]] = mem_wdata;
                        wb_count++;
                        wb_addr = mem_address;
                        wb_data = mem_wdata;
                    end else begin
                        mem_rdata = mem_line[mem_address[15:2]];
                    end
                    mem_ready = 1'b1;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reset drops unwritten-back stores, so the expected word view falls back to memory
    task automatic model_reset();
        logic [15:0] base;
        for (int i = 0; i < 8; i++) begin
            if (m_valid[i] && m_dirty[i]) begin
                base = {m_tag[i], 3'(i), 2'b00};
                for (int w = 0; w < 4; w++)
                    ref_word[base + 16'(w)] = mem_line[base[15:2]][16*w +: 16];
            end
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        m_hits = 0;
        m_misses = 0;
    endtask

    task automatic access(input logic rd, input logic wr, input logic [15:0] addr,
                          input logic [15:0] wdata, input string name);
        logic [2:0]  idx;
        logic [10:0] tg;
        bit          is_hit, is_dirty, overlap, rd_seen;
        int          exp_cyc, n, wb0;
        logic [15:0] exp_wb_addr, rd_addr;
        logic [63:0] exp_wb;
        idx = addr[4:2];
        tg  = addr[15:5];
        is_hit   = m_valid[idx] && (m_tag[idx] == tg);
        is_dirty = !is_hit && m_valid[idx] && m_dirty[idx];
        exp_cyc  = is_hit ? 0 : (is_dirty ? 2*lat + 2 : lat + 1);
        exp_wb_addr = {m_tag[idx], idx, 2'b00};
        exp_wb = '0;
        for (int w = 0; w < 4; w++) exp_wb[16*w +: 16] = ref_word[exp_wb_addr + 16'(w)];
        wb0 = wb_count;
        overlap = 1'b0;
        rd_seen = 1'b0;
        rd_addr = '0;

        @(posedge clk);
        #1;
        cpu_read = rd; cpu_write = wr; cpu_address = addr; cpu_wdata = wdata;
        n = 0;
        forever begin
            @(negedge clk);
            if (mem_read && mem_write) overlap = 1'b1;
            if (mem_read && !rd_seen) begin
                rd_seen = 1'b1;
                rd_addr = mem_address;
            end
            if (cpu_ready) break;
            n++;
            if (n > 100) break;
        end

        checks++;
        if (n !== exp_cyc) begin
            errors++;
            $display("FAIL %s stall cycles: got %0d expected %0d", name, n, exp_cyc);
        end
        if (rd && !wr) begin
            checks++;
            if (cpu_rdata !== ref_word[addr]) begin
                errors++;
                $display("FAIL %s rdata @%h: got %h expected %h", name, addr, cpu_rdata, ref_word[addr]);
            end
        end
        checks++;
        if (overlap) begin
            errors++;
            $display("FAIL %s mem_read/mem_write overlap: got 1 expected 0", name);
        end
        if (!is_hit) begin
            checks++;
            if (rd_addr !== {addr[15:2], 2'b00}) begin
                errors++;
                $display("FAIL %s fill address: got %h expected %h", name, rd_addr, {addr[15:2], 2'b00});
            end
        end
        checks++;
        if (wb_count !== wb0 + (is_dirty ? 1 : 0)) begin
            errors++;
            $display("FAIL %s write-back count: got %0d expected %0d", name, wb_count - wb0, is_dirty ? 1 : 0);
        end
        if (is_dirty) begin
            checks++;
            if (wb_addr !== exp_wb_addr || wb_data !== exp_wb) begin
                errors++;
                $display("FAIL %s write-back: got %h/%h expected %h/%h", name, wb_addr, wb_data, exp_wb_addr, exp_wb);
            end
        end

        if (is_hit) m_hits++;
        else begin
            m_misses++;
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
            m_dirty[idx] = 1'b0;
        end
        if (wr) begin
            ref_word[addr] = wdata;
            m_dirty[idx] = 1'b1;
        end

        @(posedge clk);
        #1;
        cpu_read = 1'b0;
        cpu_write = 1'b0;
`ifdef CACHE_STATS_EN
        checks++;
        if (num_hit !== 16'(m_hits) || num_miss !== 16'(m_misses)) begin
            errors++;
            $display("FAIL %s counters: got %0d/%0d expected %0d/%0d", name, num_hit, num_miss, m_hits, m_misses);
        end
`endif
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        @(negedge clk);
        checks++;
        if (cpu_ready !== 1'b0 || cpu_rdata !== 16'h0 || mem_read !== 1'b0 || mem_write !== 1'b0 ||
            mem_address !== 16'h0 || mem_wdata !== 64'h0) begin
            errors++;
            $display("FAIL reset outputs: got rdy=%b rdata=%h mr=%b mw=%b ma=%h mwd=%h expected all 0",
                     cpu_ready, cpu_rdata, mem_read, mem_write, mem_address, mem_wdata);
        end
`ifdef CACHE_STATS_EN
        checks++;
        if (num_hit !== 16'h0 || num_miss !== 16'h0) begin
            errors++;
            $display("FAIL reset counters: got %0d/%0d expected 0/0", num_hit, num_miss);
        end
`endif
    endtask

    task automatic test_clean_miss();
        lat = 3;
        access(1'b1, 1'b0, 16'h0010, 16'h0, "clean_miss");
    endtask

    task automatic test_hit();
        access(1'b1, 1'b0, 16'h0012, 16'h0, "hit_read");
    endtask

    task automatic test_dirty_evict();
        access(1'b0, 1'b1, 16'h0011, 16'hBEEF, "hit_write");
        access(1'b1, 1'b0, 16'h0031, 16'h0, "dirty_evict");
        checks++;
        if (wb_data !== {16'd4, 16'd3, 16'hBEEF, 16'd1} || wb_addr !== 16'h0010) begin
            errors++;
            $display("FAIL dirty_evict victim: got %h/%h expected 0010/0004000300beef0001", wb_addr, wb_data);
        end
    endtask

    task automatic test_reevict();
        access(1'b1, 1'b0, 16'h0031, 16'h0, "rehit");
        access(1'b1, 1'b0, 16'h0011, 16'h0, "clean_reevict");
    endtask

    task automatic test_stats();
`ifdef CACHE_STATS_EN
        checks++;
        if (num_hit !== 16'd3 || num_miss !== 16'd3) begin
            errors++;
            $display("FAIL stats after directed: got %0d/%0d expected 3/3", num_hit, num_miss);
        end
`endif
    endtask

    task automatic test_reset_mid_miss();
        test_reset();
        lat = 3;
        @(posedge clk);
        #1;
        cpu_read = 1'b1;
        cpu_address = 16'h0044;
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        cpu_read = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_read !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_miss request: got mem_read=%b expected 1", mem_read);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        @(negedge clk);
        checks++;
        if (mem_read !== 1'b0 || mem_address !== 16'h0 || cpu_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_miss abort: got mr=%b ma=%h rdy=%b expected 0/0000/0", mem_read, mem_address, cpu_ready);
        end
        access(1'b1, 1'b0, 16'h0044, 16'h0, "after_abort");
    endtask

    task automatic test_dropped_request();
        bit ready_seen;
        lat = 2;
        @(posedge clk);
        #1;
        cpu_read = 1'b1;
        cpu_address = 16'h0088;
        @(posedge clk);
        #1;
        cpu_read = 1'b0;
        ready_seen = 1'b0;
        repeat (lat + 4) begin
            @(negedge clk);
            if (cpu_ready) ready_seen = 1'b1;
        end
        checks++;
        if (ready_seen || mem_read !== 1'b0) begin
            errors++;
            $display("FAIL dropped_request: got ready_seen=%b mem_read=%b expected 0/0", ready_seen, mem_read);
        end
        m_misses++;
        m_valid[2] = 1'b1;
        m_tag[2]   = 11'h004;
        m_dirty[2] = 1'b0;
        access(1'b1, 1'b0, 16'h008A, 16'h0, "after_drop");
    endtask

    task automatic test_random();
        logic [15:0] addr;
        int op;
        for (int i = 0; i < 300; i++) begin
            lat  = int'($urandom_range(1, 4));
            addr = {11'($urandom_range(0, 3)), 5'($urandom)};
            op   = int'($urandom_range(0, 3));
            access(op >= 2 ? (op == 3) : 1'b1, op >= 2, addr, 16'($urandom), "random");
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) ref_word[i] = 16'($urandom);
        ref_word[16'h0010] = 16'd1;
        ref_word[16'h0011] = 16'd2;
        ref_word[16'h0012] = 16'd3;
        ref_word[16'h0013] = 16'd4;
        for (int j = 0; j < 16384; j++)
            mem_line[j] = {ref_word[4*j+3], ref_word[4*j+2], ref_word[4*j+1], ref_word[4*j]};

        test_reset();
        test_clean_miss();
        test_hit();
        test_dirty_evict();
        test_reevict();
        test_stats();
        test_reset_mid_miss();
        test_dropped_request();
        test_random();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
